tilt_direction_decoder: RTL and testbench
=========================================

TILT_DIRECTION_DECODER -- requirements
Module: tilt_direction_decoder

Interface
REQ-001 Parameter AXIS_W, default 5: width of each signed accelerometer axis field.
REQ-002 Parameter THRESH_ON, default 8: tilt magnitude at or above which a direction qualifies.
REQ-003 Parameter THRESH_OFF, default 4: magnitude below which an active direction drops out; THRESH_OFF <= THRESH_ON.
REQ-004 Parameter STABLE_CNT, default 3: number of consecutive agreeing samples required to change a direction level.
REQ-005 Parameter DIAG_EN, default 0: 1 allows one X and one Y direction simultaneously; 0 enforces a single active direction.
REQ-006 Parameter REPEAT_EN, default 1: enables auto-repeat press pulses while a direction is held.
REQ-007 Parameter REPEAT_DLY, default 4; parameter REPEAT_RATE, default 2: auto-repeat delay and period, both counted in samples.
REQ-008 Port clk, input, 1 bit: single system clock.
REQ-009 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 Port enable, input, 1 bit: decoder active when high.
REQ-011 Port acl_data, input, 3*AXIS_W bits: {X, Y, Z} two's-complement fields, with X in the MSBs and Z ignored.
REQ-012 Port acl_valid, input, 1 bit: one-cycle strobe marking a new sample; it is synchronous to clk.
REQ-013 Port dir_level, output, 4 bits: debounced held directions, indexed {DOWN=3, UP=2, LEFT=1, RIGHT=0}.
REQ-014 Port dir_press, output, 4 bits: one-cycle press pulses, one bit per direction.

Function
REQ-015 Samples are processed only in cycles with acl_valid=1 and enable=1; all other cycles hold state.
REQ-016 Raw qualification on entry: RIGHT if X >= +THRESH_ON; LEFT if X <= -THRESH_ON; UP if Y >= +THRESH_ON; DOWN if Y <= -THRESH_ON.
REQ-017 Hysteresis: a direction whose level is 1 remains raw-qualified while |axis| >= THRESH_OFF with the same sign.
REQ-018 Magnitude is computed in AXIS_W+1 bits, so -2^(AXIS_W-1) yields full magnitude without overflow.
REQ-019 DIAG_EN=0 with both axes qualified: only the larger-magnitude axis qualifies; on a tie, X wins.
REQ-020 Per direction: a counter increments on each sample whose raw value differs from dir_level and clears on each agreeing sample.
REQ-021 When that counter reaches STABLE_CNT, dir_level toggles and the counter clears.
REQ-022 Latency: dir_level changes at the clk edge following the acl_valid cycle of the STABLE_CNT-th consecutive disagreeing sample.
REQ-023 dir_press pulses high for exactly one clk cycle, coincident with each 0->1 transition of dir_level; a 1->0 transition produces no pulse.
REQ-024 With REPEAT_EN=1 and a level held, dir_press also pulses REPEAT_DLY samples after the rise, then every REPEAT_RATE samples after that.
REQ-025 The repeat counter clears on level fall and on enable low.
REQ-026 enable low forces dir_level=0 and dir_press=0 and clears all counters; operation restarts from zero on re-enable.

Reset
REQ-027 reset_n low asynchronously clears dir_level, dir_press, the debounce counters and the repeat counters to 0.
REQ-028 Reset deassertion is synchronised to clk; the first sample is accepted no earlier than the second clk edge after release.

Structure
REQ-029 Shared package tilt_pkg holds the direction index constants (DIR_RIGHT..DIR_DOWN) and the default threshold and count constants.
REQ-030 Sub-module tilt_dir_channel (debounce counter, level, press and repeat logic) is instantiated four times; the top level holds field extraction, hysteresis and exclusivity.

Verification (AXIS_W=5, ON=8, OFF=4, STABLE_CNT=3, REPEAT_EN=0 unless stated)
REQ-031 X=+10 for 2 samples, then X=0 -> no level change, no press; X=+10 for 3 samples -> dir_level=0001 and one dir_press=0001 pulse after the 3rd valid.
REQ-032 RIGHT held, then X=+6 for 5 samples -> level stays 1; then X=+3 for 3 samples -> level=0 with no press pulse.
REQ-033 DIAG_EN=0: X=+9, Y=-12 -> only DOWN (1000); X=+9, Y=+9 -> only RIGHT (0001); DIAG_EN=1 with X=+9, Y=+9 -> 0101.
REQ-034 REPEAT_EN=1, DLY=4, RATE=2: X=+10 for 12 samples -> RIGHT press pulses at samples 3, 7, 9 and 11 only.
REQ-035 X=-16 (10000b) for 3 samples -> dir_level=0010.
REQ-036 reset_n low mid-debounce (2 of 3 samples) -> outputs 0 immediately; 3 fresh samples are then required for assertion. The same sequence with enable low in place of reset_n gives the same result.

Source files
------------

// File: rtl/tilt_pkg.sv
// Shared constants for the tilt direction decoder.
// Direction indices into the 4-bit level/press vectors, default thresholds
// and counts, and the per-channel auto-repeat state encoding.
package tilt_pkg;

  localparam int unsigned NUM_DIRS = 4;

  // Direction bit positions in dir_level / dir_press
  localparam int unsigned DIR_RIGHT = 0;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_UP    = 2;
  localparam int unsigned DIR_DOWN  = 3;

  // Default parameter values
  localparam int unsigned DEF_AXIS_W      = 5;
  localparam int unsigned DEF_THRESH_ON   = 8;
  localparam int unsigned DEF_THRESH_OFF  = 4;
  localparam int unsigned DEF_STABLE_CNT  = 3;
  localparam int unsigned DEF_REPEAT_DLY  = 4;
  localparam int unsigned DEF_REPEAT_RATE = 2;

  // Auto-repeat phase of one direction channel
  typedef enum logic [1:0] {
    REP_OFF   = 2'd0,  // level low
    REP_DELAY = 2'd1,  // level high, waiting out the initial repeat delay
    REP_RATE  = 2'd2   // level high, pulsing every REPEAT_RATE samples
  } rep_state_e;

endpackage

// File: rtl/tilt_dir_channel.sv
// One direction channel: sample debounce, held level, press pulse and
// auto-repeat.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset (already release-synchronised)
//   en_i     - channel enable; low clears all state at the next edge
//   sample_i - a new accelerometer sample is present this cycle
//   raw_i    - raw (hysteresis/exclusivity filtered) qualification
//   level_o  - debounced held level
//   press_o  - one-cycle press pulse on rise and on each auto-repeat
module tilt_dir_channel
  import tilt_pkg::*;
#(
  parameter int unsigned STABLE_CNT  = DEF_STABLE_CNT,
  parameter int unsigned REPEAT_EN   = 1,
  parameter int unsigned REPEAT_DLY  = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_RATE = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic sample_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW   = $clog2(STABLE_CNT + 1);
  localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  rep_state_e    state_q, state_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0] rep_q, rep_d, rep_inc;
  logic          toggle;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REP_OFF;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
    end
  end

  // Debounce, level toggle and repeat sequencing
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    toggle  = 1'b0;
    cnt_inc = cnt_q + CW'(1);
    rep_inc = rep_q + RW'(1);

    if (!en_i) begin
      state_d = REP_OFF;
      level_d = 1'b0;
      cnt_d   = '0;
      rep_d   = '0;
    end else if (sample_i) begin
      // Count consecutive disagreeing samples; any agreeing sample restarts
      if (raw_i != level_q) begin
        if (cnt_inc == CW'(STABLE_CNT)) begin
          toggle = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cnt_d = '0;
      end

      if (toggle) begin
        level_d = !level_q;
        rep_d   = '0;
        if (!level_q) begin
          press_d = 1'b1;
          state_d = REP_DELAY;
        end else begin
          state_d = REP_OFF;
        end
      end else if (REPEAT_EN != 0) begin
        // Repeat counter counts samples since the rise / last repeat pulse
        case (state_q)
          REP_DELAY: begin
            if (rep_inc == RW'(REPEAT_DLY)) begin
              press_d = 1'b1;
              rep_d   = '0;
              state_d = REP_RATE;
            end else begin
              rep_d = rep_inc;
            end
          end
          REP_RATE: begin
            if (rep_inc == RW'(REPEAT_RATE)) begin
              press_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d = rep_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/tilt_direction_decoder.sv
// Tilt direction decoder: turns {X, Y, Z} accelerometer samples into
// debounced direction levels and press pulses.
// Ports:
//   clk       - system clock
//   reset_n   - asynchronous active-low reset; release is synchronised
//   enable    - decoder active when high; low clears all state
//   acl_data  - {X, Y, Z} signed fields, X in the MSBs, Z ignored
//   acl_valid - one-cycle new-sample strobe
//   dir_level - debounced levels {DOWN, UP, LEFT, RIGHT}
//   dir_press - one-cycle press pulses, same bit order
module tilt_direction_decoder
  import tilt_pkg::*;
#(
  parameter int unsigned AXIS_W      = DEF_AXIS_W,
  parameter int unsigned THRESH_ON   = DEF_THRESH_ON,
  parameter int unsigned THRESH_OFF  = DEF_THRESH_OFF,
  parameter int unsigned STABLE_CNT  = DEF_STABLE_CNT,
  parameter int unsigned DIAG_EN     = 0,
  parameter int unsigned REPEAT_EN   = 1,
  parameter int unsigned REPEAT_DLY  = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_RATE = DEF_REPEAT_RATE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [3*AXIS_W-1:0]   acl_data,
  input  logic                  acl_valid,
  output logic [NUM_DIRS-1:0]   dir_level,
  output logic [NUM_DIRS-1:0]   dir_press
);

  // Magnitudes carry one extra bit so the most negative value fits
  localparam int unsigned MW = AXIS_W + 1;

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  logic [AXIS_W-1:0] x, y;
  logic [MW-1:0]     x_ext, y_ext, mag_x, mag_y;
  logic              x_pos, x_neg, y_pos, y_neg;
  logic [NUM_DIRS-1:0] qual, raw;
  logic              sample;
  logic              unused_z;

  // Reset synchroniser: asserts asynchronously, releases after two edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n = rst_sync_q[1];

  // Field extraction and magnitude
  assign x        = acl_data[3*AXIS_W-1 -: AXIS_W];
  assign y        = acl_data[2*AXIS_W-1 -: AXIS_W];
  assign unused_z = ^acl_data[AXIS_W-1:0];
  assign x_ext    = {x[AXIS_W-1], x};
  assign y_ext    = {y[AXIS_W-1], y};
  assign mag_x    = x[AXIS_W-1] ? (~x_ext + MW'(1)) : x_ext;
  assign mag_y    = y[AXIS_W-1] ? (~y_ext + MW'(1)) : y_ext;
  assign x_neg    = x[AXIS_W-1];
  assign y_neg    = y[AXIS_W-1];
  assign x_pos    = !x[AXIS_W-1] && (x != '0);
  assign y_pos    = !y[AXIS_W-1] && (y != '0);
  assign sample   = acl_valid && enable;

  // Entry threshold for idle directions, lower exit threshold for held ones
  always_comb begin
    qual = '0;
    qual[DIR_RIGHT] = x_pos && (mag_x >= (dir_level[DIR_RIGHT] ? MW'(THRESH_OFF) : MW'(THRESH_ON)));
    qual[DIR_LEFT]  = x_neg && (mag_x >= (dir_level[DIR_LEFT]  ? MW'(THRESH_OFF) : MW'(THRESH_ON)));
    qual[DIR_UP]    = y_pos && (mag_y >= (dir_level[DIR_UP]    ? MW'(THRESH_OFF) : MW'(THRESH_ON)));
    qual[DIR_DOWN]  = y_neg && (mag_y >= (dir_level[DIR_DOWN]  ? MW'(THRESH_OFF) : MW'(THRESH_ON)));
  end

  // Single-direction mode: larger axis wins, X wins a tie
  always_comb begin
    raw = qual;
    if (DIAG_EN == 0) begin
      if ((qual[DIR_RIGHT] || qual[DIR_LEFT]) && (qual[DIR_UP] || qual[DIR_DOWN])) begin
        if (mag_y > mag_x) begin
          raw[DIR_RIGHT] = 1'b0;
          raw[DIR_LEFT]  = 1'b0;
        end else begin
          raw[DIR_UP]    = 1'b0;
          raw[DIR_DOWN]  = 1'b0;
        end
      end
    end
  end

  // One debounce/press channel per direction
  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_ch
    tilt_dir_channel #(
      .STABLE_CNT (STABLE_CNT),
      .REPEAT_EN  (REPEAT_EN),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_RATE(REPEAT_RATE)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (enable),
      .sample_i(sample),
      .raw_i   (raw[i]),
      .level_o (dir_level[i]),
      .press_o (dir_press[i])
    );
  end

endmodule

// File: tb/tb_tilt_direction_decoder.sv
// Directed bench for tilt_direction_decoder. Three instances share the
// stimulus: single-direction without repeat, diagonal without repeat, and
// single-direction with auto-repeat.
module tb_tilt_direction_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [14:0] acl_data;
  logic        acl_valid;
  logic [3:0]  lvl_a, prs_a, lvl_d, prs_d, lvl_r, prs_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tilt_direction_decoder #(.DIAG_EN(0), .REPEAT_EN(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .acl_data(acl_data),
    .acl_valid(acl_valid), .dir_level(lvl_a), .dir_press(prs_a));

  tilt_direction_decoder #(.DIAG_EN(1), .REPEAT_EN(0)) dut_d (
    .clk(clk), .reset_n(reset_n), .enable(enable), .acl_data(acl_data),
    .acl_valid(acl_valid), .dir_level(lvl_d), .dir_press(prs_d));

  tilt_direction_decoder #(.DIAG_EN(0), .REPEAT_EN(1), .REPEAT_DLY(4), .REPEAT_RATE(2)) dut_r (
    .clk(clk), .reset_n(reset_n), .enable(enable), .acl_data(acl_data),
    .acl_valid(acl_valid), .dir_level(lvl_r), .dir_press(prs_r));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One valid sample; returns at the negedge after it was captured
  task automatic send(input int x, input int y);
    @(negedge clk);
    acl_data  = {x[4:0], y[4:0], 5'b10101};
    acl_valid = 1'b1;
    @(negedge clk);
    acl_valid = 1'b0;
  endtask

  task automatic send_n(input int x, input int y, input int n);
    repeat (n) send(x, y);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    acl_valid = 1'b0;
    acl_data  = '0;
    repeat (2) @(negedge clk);
    chk("reset_level", lvl_a, 4'b0000);
    chk("reset_press", prs_a, 4'b0000);

    // Sample at the first edge after release must be ignored
    reset_n   = 1'b1;
    acl_data  = {5'd10, 5'd0, 5'd0};
    acl_valid = 1'b1;
    @(negedge clk);
    acl_valid = 1'b0;
    send_n(10, 0, 2);
    chk("sync_first_edge_ignored", lvl_a, 4'b0000);
    send(10, 0);
    chk("sync_third_sample", lvl_a, 4'b0001);

    // Interrupted debounce, then a full debounce with one press pulse
    do_reset();
    send_n(10, 0, 2);
    chk("deb_two_samples", lvl_a, 4'b0000);
    send(0, 0);
    chk("deb_interrupted", lvl_a, 4'b0000);
    chk("deb_interrupted_press", prs_a, 4'b0000);
    send_n(10, 0, 2);
    chk("deb_restart_two", lvl_a, 4'b0000);
    send(10, 0);
    chk("right_level", lvl_a, 4'b0001);
    chk("right_press", prs_a, 4'b0001);
    @(negedge clk);
    chk("right_press_one_cycle", prs_a, 4'b0000);

    // Hysteresis hold and release without a press
    send_n(6, 0, 5);
    chk("hyst_hold", lvl_a, 4'b0001);
    send_n(3, 0, 2);
    chk("hyst_release_pending", lvl_a, 4'b0001);
    send(3, 0);
    chk("hyst_released", lvl_a, 4'b0000);
    chk("hyst_no_press_on_fall", prs_a, 4'b0000);

    // Most negative X qualifies as LEFT
    do_reset();
    send_n(-16, 0, 3);
    chk("left_min_value", lvl_a, 4'b0010);
    chk("left_press", prs_a, 4'b0010);

    // UP threshold boundary, hold at exactly OFF, opposite sign drops out
    do_reset();
    send_n(0, 7, 3);
    chk("up_below_on", lvl_a, 4'b0000);
    send_n(0, 8, 3);
    chk("up_at_on", lvl_a, 4'b0100);
    send_n(0, 4, 3);
    chk("up_hold_at_off", lvl_a, 4'b0100);
    send_n(0, -4, 3);
    chk("up_opposite_sign", lvl_a, 4'b0000);

    // Exclusivity and diagonal mode
    do_reset();
    send_n(9, -12, 3);
    chk("excl_y_larger", lvl_a, 4'b1000);
    chk("diag_right_down", lvl_d, 4'b1001);
    do_reset();
    send_n(9, 9, 3);
    chk("excl_tie_x_wins", lvl_a, 4'b0001);
    chk("diag_right_up", lvl_d, 4'b0101);

    // Auto-repeat: pulses at samples 3, 7, 9, 11
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      send(10, 0);
      chk($sformatf("repeat_s%0d", i), prs_r,
          (i == 3 || i == 7 || i == 9 || i == 11) ? 4'b0001 : 4'b0000);
    end
    chk("repeat_level", lvl_r, 4'b0001);

    // Asynchronous reset clears a held level immediately
    do_reset();
    send_n(10, 0, 3);
    chk("pre_async_level", lvl_a, 4'b0001);
    #3 reset_n = 1'b0;
    #1 chk("async_reset_level", lvl_a, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset mid-debounce discards the partial count
    send_n(10, 0, 2);
    #2 reset_n = 1'b0;
    #1 chk("reset_mid_deb", lvl_a, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    send_n(10, 0, 2);
    chk("reset_fresh_two", lvl_a, 4'b0000);
    send(10, 0);
    chk("reset_fresh_three", lvl_a, 4'b0001);

    // Enable low clears level and counters; samples while low are ignored
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("enable_low_clears", lvl_a, 4'b0000);
    send_n(10, 0, 3);
    chk("enable_low_ignores", lvl_a, 4'b0000);
    enable = 1'b1;
    send_n(10, 0, 2);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    send_n(10, 0, 2);
    chk("enable_fresh_two", lvl_a, 4'b0000);
    send(10, 0);
    chk("enable_fresh_three", lvl_a, 4'b0001);
    chk("enable_fresh_press", prs_a, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
